tdm_demux_4: RTL and testbench
==============================

Name: tdm_demux_4

Overview:
Receive end of the 4-channel time-division link built from our 4:1 mux: accepts one W-bit sample per valid cycle plus a slot-0 sync marker. Steers each sample into one of four channel lanes. Once all four slots are collected, presents a complete frame on y0..y3 atomically. Tracks frame alignment and flags sync errors.

Parameters:
W, 1, width of each channel sample and of din.
STRICT_SYNC, 1, 1 = sync required on every slot-0 sample; 0 = sync needed only to acquire lock.

Ports:
clk  input  1  single system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  W  serial TDM sample
din_valid  input  1  din carries a sample this cycle
sync  input  1  marks current sample as slot 0; ignored when din_valid=0
y0  output  W  channel 0 lane, registered
y1  output  W  channel 1 lane, registered
y2  output  W  channel 2 lane, registered
y3  output  W  channel 3 lane, registered
frame_valid  output  1  one-cycle pulse: y0..y3 just updated with a full frame
sel  output  2  slot index the next accepted sample will occupy ({s1,s0} order)
locked  output  1  1 in LOCKED state
sync_err  output  1  one-cycle pulse on alignment violation

Behaviour:
- Reset (rst_n low, asynchronous): y0..y3=0, frame_valid=0, sync_err=0, sel=0, locked=0, state=HUNT, shadow lanes 0..2 = 0. Release takes effect on the next clk edge.
- Accepted sample = din_valid=1 at a rising edge. din_valid=0: no state change, frame_valid/sync_err deassert.
- HUNT:
  - Samples without sync are discarded; sel stays 0.
  - Sample with sync: store in shadow0, sel=1, go to LOCKED, locked=1 on that edge.
- LOCKED, accepted sample at slot s:
  - s=1 or 2, no sync: store in shadow[s], sel=s+1.
  - s=3, no sync: y0<=shadow0, y1<=shadow1, y2<=shadow2, y3<=din, all on the same edge. frame_valid=1 for exactly that cycle. sel wraps to 0.
  - s=0 with sync: store in shadow0, sel=1.
  - s=0 without sync:
    - STRICT_SYNC=1: sync_err=1, sample discarded, go to HUNT, locked=0, sel=0.
    - STRICT_SYNC=0: treat as slot 0 normally.
  - s≠0 with sync (early sync): sync_err=1, partial frame discarded (y0..y3 unchanged, no frame_valid). Sample stored as slot 0, sel=1, stay LOCKED.
- Latency: a frame's slot-3 sample and the frame_valid pulse appear on the same edge. Minimum 4 accepted samples per frame.
- y0..y3 hold their last complete frame indefinitely; never partially updated.
- frame_valid and sync_err are never asserted for more than one consecutive cycle unless re-triggered by the next accepted sample.
- sync_err and frame_valid are mutually exclusive in a cycle.
- Reset mid-frame: shadow contents lost, outputs cleared, back to HUNT.
- Shadow lanes written only via a one-hot write enable decoded from sel, gated by an accepted sample.

Decomposition:
- Package tdm_pkg:
  - localparam NUM_SLOTS=4 and SLOT_W=2.
  - state enum {HUNT, LOCKED}.
  - slot_t typedef (SLOT_W bits).
- Sub-module dec_2_4: combinational 2-to-4 one-hot decoder with enable, producing shadow-lane write enables from sel and the accepted-sample strobe.
- All other logic in tdm_demux_4.

Test Plan:
- W=4, reset, then samples A,B,C,D with sync on A and din_valid continuous -> on the D edge y0=A, y1=B, y2=C, y3=D; frame_valid=1 for one cycle; locked=1 from the A edge; sel sequence 1,2,3,0.
- In HUNT, feed 3 samples without sync, then sync+1,2,3,4 -> first 3 ignored; frame {1,2,3,4}; sync_err never asserted.
- Locked, send 5,6 then sync+7,8,9,A -> sync_err pulse on the 7 edge; frame {5,6,..} never appears; next frame is y0..y3={7,8,9,A}.
- STRICT_SYNC=1, locked, slot-0 sample without sync -> sync_err=1, locked=0, sel=0, y lanes keep previous frame. With STRICT_SYNC=0 the same stimulus -> no error, frame completes normally.
- Gaps: sync+1, din_valid=0 for 3 cycles, 2, gap, 3, 4 -> frame {1,2,3,4}; sel holds during gaps; frame_valid only on the 4 edge.
- Assert rst_n low asynchronously (between clk edges) after 2 samples -> all outputs 0 immediately, locked=0. After release, a fresh sync frame {E,F,0,1} is received correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM receive path.
//   NUM_SLOTS : samples per frame
//   SLOT_W    : width of a slot index
//   state_e   : frame-alignment state (hunting for sync / locked to it)
//   slot_t    : slot index type
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    StHunt,
    StLocked
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/dec_2_4.sv
// 2-to-4 one-hot decoder with enable.
//   en     : when low, all outputs are low
//   sel    : index of the output to raise
//   onehot : one-hot decode of sel, gated by en
module dec_2_4
  import tdm_pkg::*;
(
  input  logic                 en,
  input  slot_t                sel,
  output logic [NUM_SLOTS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux_4.sv
// Receive end of the 4-channel TDM link. Collects four consecutive accepted samples
// (slot 0 marked by sync) into shadow lanes and publishes them on y0..y3 in one edge.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : serial TDM sample, accepted when din_valid is high
//   sync        : current sample is slot 0 (ignored without din_valid)
//   y0..y3      : last complete frame, registered
//   frame_valid : one-cycle pulse when y0..y3 load a new frame
//   sel         : slot the next accepted sample will occupy
//   locked      : frame alignment acquired
//   sync_err    : one-cycle pulse on an alignment violation
module tdm_demux_4
  import tdm_pkg::*;
#(
  parameter int unsigned W           = 1,
  parameter bit          STRICT_SYNC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic         frame_valid,
  output logic [1:0]   sel,
  output logic         locked,
  output logic         sync_err
);

  state_e               state_q, state_d;
  slot_t                sel_q, sel_d;
  logic                 sync_err_q, sync_err_d;
  logic                 frame_valid_q;
  logic [W-1:0]         shadow_q [NUM_SLOTS-1];
  logic [W-1:0]         y_q      [NUM_SLOTS];
  slot_t                wr_slot;
  logic                 wr_en;
  logic [NUM_SLOTS-1:0] lane_we;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    sync_err_d = 1'b0;
    wr_slot    = sel_q;
    wr_en      = 1'b0;
    if (din_valid) begin
      if (sync) begin
        // A sync sample always restarts the frame at slot 0; mid-frame it also
        // discards the partial frame and flags the misalignment.
        wr_slot    = '0;
        wr_en      = 1'b1;
        sel_d      = slot_t'(1);
        state_d    = StLocked;
        sync_err_d = (state_q == StLocked) && (sel_q != '0);
      end else if (state_q == StLocked) begin
        if ((sel_q == '0) && STRICT_SYNC) begin
          sync_err_d = 1'b1;
          state_d    = StHunt;
          sel_d      = '0;
        end else begin
          wr_en = 1'b1;
          sel_d = sel_q + 1'b1;
        end
      end
    end
  end

  // Lanes 0..2 go to shadow storage; lane 3 is the frame-complete strobe.
  dec_2_4 u_dec (
    .en     (wr_en),
    .sel    (wr_slot),
    .onehot (lane_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      sel_q         <= '0;
      sync_err_q    <= 1'b0;
      frame_valid_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SLOTS; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      sync_err_q    <= sync_err_d;
      frame_valid_q <= lane_we[NUM_SLOTS-1];
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
        if (lane_we[i]) begin
          shadow_q[i] <= din;
        end
      end
      if (lane_we[NUM_SLOTS-1]) begin
        for (int i = 0; i < NUM_SLOTS - 1; i++) begin
          y_q[i] <= shadow_q[i];
        end
        y_q[NUM_SLOTS-1] <= din;
      end
    end
  end

  assign y0          = y_q[0];
  assign y1          = y_q[1];
  assign y2          = y_q[2];
  assign y3          = y_q[3];
  assign frame_valid = frame_valid_q;
  assign sel         = sel_q;
  assign locked      = (state_q == StLocked);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed bench for tdm_demux_4 (W=4). Two instances share stimulus: one with strict
// slot-0 sync checking, one with lax checking.
module tb_tdm_demux_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       sync;

  logic [3:0] y0_s, y1_s, y2_s, y3_s, y0_l, y1_l, y2_l, y3_l;
  logic       fv_s, fv_l, lk_s, lk_l, se_s, se_l;
  logic [1:0] sel_s, sel_l;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tdm_demux_4 #(.W(4), .STRICT_SYNC(1'b1)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y0          (y0_s),
    .y1          (y1_s),
    .y2          (y2_s),
    .y3          (y3_s),
    .frame_valid (fv_s),
    .sel         (sel_s),
    .locked      (lk_s),
    .sync_err    (se_s)
  );

  tdm_demux_4 #(.W(4), .STRICT_SYNC(1'b0)) dut_l (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sync        (sync),
    .y0          (y0_l),
    .y1          (y1_l),
    .y2          (y2_l),
    .y3          (y3_l),
    .frame_valid (fv_l),
    .sel         (sel_l),
    .locked      (lk_l),
    .sync_err    (se_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected frame given as {y3,y2,y1,y0}.
  task automatic chk_s(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, y3_s, y2_s, y1_s, y0_s}, {16'h0, exp});
  endtask

  task automatic chk_l(input string tag, input logic [15:0] exp);
    chk(tag, {16'h0, y3_l, y2_l, y1_l, y0_l}, {16'h0, exp});
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic tick(input logic v, input logic s, input logic [3:0] d);
    din_valid = v;
    sync      = s;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = 4'h0;
    din_valid = 1'b0;
    sync      = 1'b0;
    #12;
    chk_s("rst_y", 16'h0000);
    chk("rst_fv", fv_s, 0);
    chk("rst_se", se_s, 0);
    chk("rst_sel", sel_s, 0);
    chk("rst_lk", lk_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame A,B,C,D
    tick(1, 1, 4'hA);
    chk("t1_lk", lk_s, 1);
    chk("t1_sel1", sel_s, 1);
    tick(1, 0, 4'hB);
    chk("t1_sel2", sel_s, 2);
    tick(1, 0, 4'hC);
    chk("t1_sel3", sel_s, 3);
    chk("t1_fv_early", fv_s, 0);
    chk_s("t1_no_partial", 16'h0000);
    tick(1, 0, 4'hD);
    chk("t1_fv", fv_s, 1);
    chk("t1_sel0", sel_s, 0);
    chk_s("t1_frame", 16'hDCBA);
    tick(0, 0, 4'h0);
    chk("t1_fv_pulse", fv_s, 0);
    chk_s("t1_hold", 16'hDCBA);

    // Hunt: unsynced samples discarded
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 0, 4'h5);
    tick(1, 0, 4'h6);
    tick(1, 0, 4'h7);
    chk("t2_hunt_lk", lk_s, 0);
    chk("t2_hunt_sel", sel_s, 0);
    chk("t2_hunt_se", se_s, 0);
    tick(1, 1, 4'h1);
    chk("t2_se0", se_s, 0);
    tick(1, 0, 4'h2);
    tick(1, 0, 4'h3);
    tick(1, 0, 4'h4);
    chk("t2_fv", fv_s, 1);
    chk("t2_se", se_s, 0);
    chk_s("t2_frame", 16'h4321);

    // Early sync discards partial frame
    tick(1, 1, 4'h5);
    tick(1, 0, 4'h6);
    tick(1, 1, 4'h7);
    chk("t3_se", se_s, 1);
    chk("t3_fv", fv_s, 0);
    chk("t3_sel", sel_s, 1);
    chk("t3_lk", lk_s, 1);
    chk_s("t3_hold", 16'h4321);
    tick(1, 0, 4'h8);
    chk("t3_se_pulse", se_s, 0);
    tick(1, 0, 4'h9);
    tick(1, 0, 4'hA);
    chk("t3_fv2", fv_s, 1);
    chk_s("t3_frame", 16'hA987);

    // Slot-0 sample without sync
    tick(1, 0, 4'hB);
    chk("t4_s_se", se_s, 1);
    chk("t4_s_lk", lk_s, 0);
    chk("t4_s_sel", sel_s, 0);
    chk_s("t4_s_hold", 16'hA987);
    chk("t4_l_se", se_l, 0);
    chk("t4_l_sel", sel_l, 1);
    chk("t4_l_lk", lk_l, 1);
    tick(1, 0, 4'hC);
    chk("t4_s_se_pulse", se_s, 0);
    tick(1, 0, 4'hD);
    tick(1, 0, 4'hE);
    chk("t4_l_fv", fv_l, 1);
    chk_l("t4_l_frame", 16'hEDCB);
    chk("t4_s_fv", fv_s, 0);
    chk_s("t4_s_hold2", 16'hA987);

    // Gaps between samples
    tick(1, 1, 4'h1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 4'hF);
      chk("t5_gap_sel", sel_s, 1);
      chk("t5_gap_fv", fv_s, 0);
    end
    tick(1, 0, 4'h2);
    tick(0, 0, 4'hF);
    chk("t5_gap2_sel", sel_s, 2);
    tick(1, 0, 4'h3);
    chk("t5_fv_early", fv_s, 0);
    tick(1, 0, 4'h4);
    chk("t5_fv", fv_s, 1);
    chk_s("t5_frame", 16'h4321);
    chk_l("t5_l_frame", 16'h4321);

    // Asynchronous reset mid-frame
    tick(1, 1, 4'h9);
    tick(1, 0, 4'h8);
    chk("t6_sel_pre", sel_s, 2);
    #2 rst_n = 1'b0;
    #1;
    chk_s("t6_rst_y", 16'h0000);
    chk("t6_rst_lk", lk_s, 0);
    chk("t6_rst_sel", sel_s, 0);
    chk("t6_rst_fv", fv_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 1, 4'hE);
    tick(1, 0, 4'hF);
    tick(1, 0, 4'h0);
    tick(1, 0, 4'h1);
    chk("t6_fv", fv_s, 1);
    chk_s("t6_frame", 16'h10FE);
    tick(0, 0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
